// File: rtl/zeroriscy_defines.sv
// Shared core definitions: MD operator codes, MD controller state enum
// and iteration count used by the iterative multiply/divide unit.
package zeroriscy_defines;

  localparam logic [1:0] MD_OP_MULL = 2'b00;
  localparam logic [1:0] MD_OP_MULH = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;
  localparam logic [1:0] MD_OP_REM  = 2'b11;

  localparam int MD_ITER = 32;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } md_state_e;

endpackage

// File: rtl/zeroriscy_md_addsub.sv
// Shared add/subtract datapath for the MD controller.
// Ports: a, b operands, sub selects a-b, sum is the W-bit result.
module zeroriscy_md_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  assign sum = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/zeroriscy_md_ctrl.sv
// Iterative shift-add multiplier / restoring divider controller.
// Ports: clk, rst (sync, active-high), start_i/operator_i/signed_mode_i,
// op_a_i/op_b_i, kill_i in; busy_o, valid_o, result_o, error_o out.
// Define ZERORISCY_MD_DIV_EN to build DIV/REM; otherwise they flag error_o.
module zeroriscy_md_ctrl
  import zeroriscy_defines::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        operator_i,
  input  logic [1:0]        signed_mode_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic              kill_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic              error_o
);

  localparam int W  = DATA_W;
  localparam int CW = $clog2(MD_ITER);

  md_state_e state_q, state_d;

  logic [1:0]    op_q, sgn_q;
  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  x_q, m_q, acc_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q;
  logic [W-1:0]  res_q;

  logic [W:0]     add_a, add_b, sum, t;
  logic           add_sub;
  logic           is_div, a_neg, b_neg, neg_d;
  logic [W-1:0]   a_abs, b_abs, fix_word;
  logic [2*W-1:0] prod, prod_fix;

`ifdef ZERORISCY_MD_DIV_EN
  logic [W:0]   r_sh;
  logic         div_zero;
  logic [W-1:0] div_word;
`else
  logic         err_q;
`endif

  zeroriscy_md_addsub #(.W(W+1)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (sum)
  );

  assign is_div   = op_q[1];
  assign a_neg    = sgn_q[0] & a_q[W-1];
  assign b_neg    = sgn_q[1] & b_q[W-1];
  assign a_abs    = a_neg ? sum[W-1:0] : a_q;
  assign b_abs    = b_neg ? (~b_q + W'(1)) : b_q;
  assign neg_d    = (op_q == MD_OP_REM) ? a_neg : (a_neg ^ b_neg);
  // mul step: accumulate |a| only when the multiplier LSB is set
  assign t        = m_q[0] ? sum : {1'b0, acc_q};
  assign prod     = {acc_q, m_q};
  assign prod_fix = neg_q ? (~prod + (2*W)'(1)) : prod;

`ifdef ZERORISCY_MD_DIV_EN
  assign r_sh     = {acc_q, m_q[W-1]};
  assign div_zero = is_div & (b_q == '0);
  assign div_word = op_q[0] ? acc_q : m_q;
`endif

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    unique case (state_q)
      PREP: begin
        add_b   = {1'b0, a_q};
        add_sub = 1'b1;
      end
      CALC: begin
        add_a = {1'b0, acc_q};
        add_b = {1'b0, x_q};
`ifdef ZERORISCY_MD_DIV_EN
        if (is_div) begin
          add_a   = r_sh;
          add_sub = 1'b1;
        end
`endif
      end
`ifdef ZERORISCY_MD_DIV_EN
      FIX: begin
        add_b   = {1'b0, div_word};
        add_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    fix_word = '0;
    unique case (op_q)
      MD_OP_MULL: fix_word = prod_fix[W-1:0];
      MD_OP_MULH: fix_word = prod_fix[2*W-1:W];
`ifdef ZERORISCY_MD_DIV_EN
      default:    fix_word = neg_q ? sum[W-1:0] : div_word;
`else
      default:    fix_word = '0;
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = PREP;
`ifdef ZERORISCY_MD_DIV_EN
      PREP: state_d = div_zero ? DONE : CALC;
`else
      PREP: state_d = is_div ? DONE : CALC;
`endif
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  always_comb begin
    busy_o   = (state_q != IDLE);
    valid_o  = (state_q == DONE) & ~kill_i;
`ifdef ZERORISCY_MD_DIV_EN
    error_o  = 1'b0;
`else
    error_o  = valid_o & err_q;
`endif
    result_o = res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      sgn_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      x_q   <= '0;
      m_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      res_q <= '0;
`ifndef ZERORISCY_MD_DIV_EN
      err_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i && !kill_i) begin
            op_q  <= operator_i;
            sgn_q <= signed_mode_i;
            a_q   <= op_a_i;
            b_q   <= op_b_i;
          end
        end
        PREP: begin
          acc_q <= '0;
          cnt_q <= CW'(MD_ITER - 1);
          neg_q <= neg_d;
          if (is_div) begin
            x_q <= b_abs;
            m_q <= a_abs;
          end else begin
            x_q <= a_abs;
            m_q <= b_abs;
          end
`ifdef ZERORISCY_MD_DIV_EN
          if (div_zero && !kill_i)
            res_q <= op_q[0] ? a_q : '1;
`else
          err_q <= is_div;
          if (is_div && !kill_i)
            res_q <= '0;
`endif
        end
        CALC: begin
          cnt_q <= cnt_q - 1'b1;
          acc_q <= t[W:1];
          m_q   <= {t[0], m_q[W-1:1]};
`ifdef ZERORISCY_MD_DIV_EN
          if (is_div) begin
            // restoring step: keep the difference only if non-negative
            if (!sum[W]) begin
              acc_q <= sum[W-1:0];
              m_q   <= {m_q[W-2:0], 1'b1};
            end else begin
              acc_q <= r_sh[W-1:0];
              m_q   <= {m_q[W-2:0], 1'b0};
            end
          end
`endif
        end
        FIX: begin
          if (!kill_i) res_q <= fix_word;
        end
        default: ;
      endcase
    end
  end

endmodule
